// File: rtl/shifter_video_planar_if.sv
// Bus-side word strobe and data for the planar video shifter.
// The fetch unit drives the master modport and the shifter receives on the slave modport.
interface shifter_video_planar_if #(
    parameter int WORD_W = 16
);
    logic              load;
    logic [WORD_W-1:0] din;

    modport master (output load, din);
    modport slave  (input  load, din);
endinterface

// File: rtl/shifter_video_planar.sv
// Planar-to-chunky video shifter: gathers PLANES interleaved bitplane words into a hold group,
// then serialises them per pixel enable into a colour index, with fine scroll and error flags.
module shifter_video_planar #(
    parameter int PLANES = 4,
    parameter int WORD_W = 16,
    localparam int LP = $clog2(PLANES),
    localparam int CW = $clog2(WORD_W * PLANES),
    localparam int SW = $clog2(WORD_W)
) (
    input  logic                  clk32,
    input  logic                  reset,
    input  logic                  pix_en,
    input  logic                  de,
    shifter_video_planar_if.slave bus,
    input  logic [LP:0]           plane_log2,
    input  logic [SW-1:0]         hscroll,
    output logic [PLANES-1:0]     color_index,
    output logic                  pix_valid,
    output logic                  underrun,
    output logic                  overflow
);

    localparam int WCW = (LP > 0) ? LP : 1;
    localparam logic [WCW-1:0] WLAST = WCW'(PLANES - 1);
    localparam logic [LP:0] LP_MAX = LP[LP:0];

    logic              load_q, load_d;
    logic              de_q, de_d;
    logic              arm_q, arm_d;
    logic [WCW-1:0]    wcnt_q, wcnt_d;
    logic              group_ready_q, group_ready_d;
    logic [WORD_W-1:0] hold_q [PLANES];
    logic [WORD_W-1:0] hold_d [PLANES];
    logic [WORD_W-1:0] sh_q [PLANES];
    logic [WORD_W-1:0] sh_d [PLANES];
    logic [CW-1:0]     pcnt_q, pcnt_d;
    logic              running_q, running_d;
    logic [LP:0]       alog_q, alog_d;
    logic [SW-1:0]     skip_q, skip_d;
    logic              underrun_q, underrun_d;
    logic              overflow_q, overflow_d;

    logic           load_edge;
    logic           de_rise;
    logic           last_pix;
    logic           slot;
    logic           do_reload;
    logic           do_stop;
    logic           accept;
    logic [WCW-1:0] base_cnt;
    logic           shift_in;
    int             a_n;
    int             glen;

    assign a_n  = 1 << alog_q;
    assign glen = (WORD_W * PLANES) >> alog_q;

    always_comb begin
        load_d        = bus.load;
        de_d          = de;
        arm_d         = arm_q;
        wcnt_d        = wcnt_q;
        group_ready_d = group_ready_q;
        hold_d        = hold_q;
        sh_d          = sh_q;
        pcnt_d        = pcnt_q;
        running_d     = running_q;
        alog_d        = alog_q;
        skip_d        = skip_q;
        shift_in      = 1'b0;

        load_edge = bus.load & ~load_q;
        de_rise   = de & ~de_q;
        last_pix  = (pcnt_q == CW'(glen - 1));
        slot      = pix_en & (~running_q | last_pix);
        do_reload = slot & group_ready_q & (de | running_q);
        do_stop   = slot & ~group_ready_q & running_q;
        // A reload empties the hold in the same cycle, so a coincident word is still accepted.
        accept    = load_edge & (~group_ready_q | do_reload);
        base_cnt  = do_reload ? '0 : wcnt_q;

        overflow_d = load_edge & group_ready_q & ~do_reload;
        underrun_d = do_stop & de;

        if (de_rise) begin
            arm_d = 1'b1;
        end

        if (accept) begin
            for (int i = 0; i < PLANES - 1; i++) begin
                hold_d[i] = hold_q[i + 1];
            end
            hold_d[PLANES - 1] = bus.din;
        end

        if (do_reload) begin
            group_ready_d = 1'b0;
        end

        if (!de) begin
            wcnt_d = '0;
        end else if (accept) begin
            if (base_cnt == WLAST) begin
                wcnt_d        = '0;
                group_ready_d = 1'b1;
            end else begin
                wcnt_d = base_cnt + 1'b1;
            end
        end

        if (do_reload) begin
            sh_d      = hold_q;
            pcnt_d    = '0;
            running_d = 1'b1;
            alog_d    = (plane_log2 > LP_MAX) ? LP_MAX : plane_log2;
            if (arm_q | de_rise) begin
                skip_d = hscroll;
                arm_d  = 1'b0;
            end
        end else if (do_stop) begin
            sh_d      = '{default: '0};
            pcnt_d    = '0;
            running_d = 1'b0;
        end else if (pix_en && running_q) begin
            pcnt_d = pcnt_q + 1'b1;
            // Low planes borrow the MSB of the plane A above them, chaining the active planes.
            for (int j = 0; j < PLANES; j++) begin
                shift_in = 1'b0;
                for (int k = 0; k < PLANES; k++) begin
                    if (k == j + a_n) begin
                        shift_in = sh_q[k][WORD_W-1];
                    end
                end
                sh_d[j] = {sh_q[j][WORD_W-2:0], shift_in};
            end
        end

        if (pix_en && !do_reload && skip_q != '0) begin
            skip_d = skip_q - 1'b1;
        end
    end

    always_ff @(posedge clk32) begin
        if (reset) begin
            load_q        <= 1'b0;
            de_q          <= 1'b0;
            arm_q         <= 1'b0;
            wcnt_q        <= '0;
            group_ready_q <= 1'b0;
            hold_q        <= '{default: '0};
            sh_q          <= '{default: '0};
            pcnt_q        <= '0;
            running_q     <= 1'b0;
            alog_q        <= '0;
            skip_q        <= '0;
            underrun_q    <= 1'b0;
            overflow_q    <= 1'b0;
        end else begin
            load_q        <= load_d;
            de_q          <= de_d;
            arm_q         <= arm_d;
            wcnt_q        <= wcnt_d;
            group_ready_q <= group_ready_d;
            hold_q        <= hold_d;
            sh_q          <= sh_d;
            pcnt_q        <= pcnt_d;
            running_q     <= running_d;
            alog_q        <= alog_d;
            skip_q        <= skip_d;
            underrun_q    <= underrun_d;
            overflow_q    <= overflow_d;
        end
    end

    always_comb begin
        color_index = '0;
        for (int j = 0; j < PLANES; j++) begin
            if (j < a_n) begin
                color_index[j] = sh_q[j][WORD_W-1];
            end
        end
    end

    assign pix_valid = running_q & (skip_q == '0);
    assign underrun  = underrun_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_shifter_video_planar.sv
// Scoreboard bench: each pixel enable pushes its hand-computed expected pixel; a monitor
// pops and compares whenever the shifter presents the pixel that enable produced.
module tb_shifter_video_planar;

    logic       clk32 = 1'b0;
    logic       reset;
    logic       pix_en;
    logic       de;
    logic [2:0] plane_log2;
    logic [3:0] hscroll;
    logic [3:0] color_index;
    logic       pix_valid;
    logic       underrun;
    logic       overflow;

    shifter_video_planar_if #(.WORD_W(16)) bus ();

    shifter_video_planar #(.PLANES(4), .WORD_W(16)) dut (
        .clk32       (clk32),
        .reset       (reset),
        .pix_en      (pix_en),
        .de          (de),
        .bus         (bus),
        .plane_log2  (plane_log2),
        .hscroll     (hscroll),
        .color_index (color_index),
        .pix_valid   (pix_valid),
        .underrun    (underrun),
        .overflow    (overflow)
    );

    always #5 clk32 = ~clk32;

    typedef struct packed {
        logic       valid;
        logic [3:0] idx;
        logic       under;
    } exp_t;

    exp_t expq[$];
    int   checks = 0;
    int   passes = 0;
    int   ovf_count = 0;
    int   und_count = 0;
    logic pe_s;
    exp_t e_s;

    task automatic checkOutput(input string name, input int actual, input int expected);
        checks++;
        if (actual == expected) passes++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    // Monitor: the pixel for an enable taken at this edge is visible just after it.
    always @(posedge clk32) begin
        pe_s = pix_en & ~reset;
        #1;
        if (overflow) ovf_count++;
        if (underrun) und_count++;
        if (pe_s) begin
            if (expq.size() == 0) begin
                checkOutput("unexpected_pixel", 1, 0);
            end else begin
                e_s = expq.pop_front();
                checkOutput("pix_valid", int'(pix_valid), int'(e_s.valid));
                checkOutput("color_index", int'(color_index), int'(e_s.idx));
                checkOutput("underrun", int'(underrun), int'(e_s.under));
            end
        end
    end

    task automatic applyStimulus(input logic v, input logic [3:0] idx, input logic u);
        exp_t e;
        e.valid = v;
        e.idx   = idx;
        e.under = u;
        expq.push_back(e);
        pix_en = 1'b1;
        @(negedge clk32);
        pix_en = 1'b0;
        @(negedge clk32);
    endtask

    task automatic loadWord(input logic [15:0] w);
        bus.load = 1'b1;
        bus.din  = w;
        @(negedge clk32);
        bus.load = 1'b0;
        @(negedge clk32);
    endtask

    task automatic startLine(input logic [2:0] pl, input logic [3:0] hs);
        plane_log2 = pl;
        hscroll    = hs;
        de         = 1'b1;
        @(negedge clk32);
    endtask

    task automatic endLine();
        de = 1'b0;
        applyStimulus(1'b0, 4'd0, 1'b0);
        @(negedge clk32);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset      = 1'b1;
        pix_en     = 1'b0;
        de         = 1'b0;
        plane_log2 = 3'd2;
        hscroll    = 4'd0;
        bus.load   = 1'b0;
        bus.din    = 16'h0000;
        repeat (3) @(negedge clk32);
        reset = 1'b0;
        @(negedge clk32);
        checkOutput("reset_color_index", int'(color_index), 0);
        checkOutput("reset_pix_valid", int'(pix_valid), 0);
        checkOutput("reset_underrun", int'(underrun), 0);
        checkOutput("reset_overflow", int'(overflow), 0);

        // Four planes: single set pixel in planes 0 and 3.
        startLine(3'd2, 4'd0);
        loadWord(16'h8000); loadWord(16'h0000); loadWord(16'h0000); loadWord(16'h8000);
        applyStimulus(1'b1, 4'b1001, 1'b0);
        for (int i = 1; i < 16; i++) applyStimulus(1'b1, 4'd0, 1'b0);
        endLine();

        // Two planes: 32-pixel group chaining planes 2/3 into 0/1.
        startLine(3'd1, 4'd0);
        loadWord(16'hAAAA); loadWord(16'h5555); loadWord(16'hFFFF); loadWord(16'h0000);
        for (int i = 0; i < 16; i++) applyStimulus(1'b1, (i % 2 == 0) ? 4'd1 : 4'd2, 1'b0);
        for (int i = 16; i < 32; i++) applyStimulus(1'b1, 4'd1, 1'b0);
        endLine();

        // One plane: 64-pixel group.
        startLine(3'd0, 4'd0);
        loadWord(16'hFFFF); loadWord(16'h0000); loadWord(16'hFFFF); loadWord(16'h0000);
        for (int i = 0; i < 64; i++) applyStimulus(1'b1, ((i / 16) % 2 == 0) ? 4'd1 : 4'd0, 1'b0);
        endLine();

        // Fine scroll of 5 across two back-to-back groups.
        startLine(3'd2, 4'd5);
        loadWord(16'hFFFF); loadWord(16'h0000); loadWord(16'h0000); loadWord(16'h0000);
        applyStimulus(1'b0, 4'd1, 1'b0);
        loadWord(16'h0000); loadWord(16'hFFFF); loadWord(16'h0000); loadWord(16'h0000);
        for (int i = 1; i < 32; i++) applyStimulus(i >= 5, (i < 16) ? 4'd1 : 4'd2, 1'b0);
        endLine();
        hscroll = 4'd0;

        // Underrun: one group with de held high.
        startLine(3'd2, 4'd0);
        loadWord(16'hFFFF); loadWord(16'hFFFF); loadWord(16'hFFFF); loadWord(16'hFFFF);
        for (int i = 0; i < 16; i++) applyStimulus(1'b1, 4'hF, 1'b0);
        applyStimulus(1'b0, 4'd0, 1'b1);
        applyStimulus(1'b0, 4'd0, 1'b0);
        checkOutput("underrun_count", und_count, 1);
        checkOutput("no_overflow_yet", ovf_count, 0);

        // Overflow: fifth word dropped; plane_log2 above range clamps to four planes.
        plane_log2 = 3'd7;
        loadWord(16'h8000); loadWord(16'h0000); loadWord(16'h8000); loadWord(16'h0000);
        loadWord(16'hFFFF);
        @(negedge clk32);
        checkOutput("overflow_count", ovf_count, 1);
        applyStimulus(1'b1, 4'b0101, 1'b0);
        for (int i = 1; i < 16; i++) applyStimulus(1'b1, 4'd0, 1'b0);
        applyStimulus(1'b0, 4'd0, 1'b1);
        checkOutput("underrun_count2", und_count, 2);

        // Reset in the middle of a group.
        loadWord(16'hFFFF); loadWord(16'hFFFF); loadWord(16'hFFFF); loadWord(16'hFFFF);
        applyStimulus(1'b1, 4'hF, 1'b0);
        applyStimulus(1'b1, 4'hF, 1'b0);
        reset = 1'b1;
        @(negedge clk32);
        reset = 1'b0;
        checkOutput("midreset_color_index", int'(color_index), 0);
        checkOutput("midreset_pix_valid", int'(pix_valid), 0);
        applyStimulus(1'b0, 4'd0, 1'b0);

        repeat (3) @(negedge clk32);
        checkOutput("scoreboard_drained", expq.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
